// File: rtl/gamma_lut_pingpong.sv
// Per-channel gamma LUT with double-banked (active/shadow) RAM and a commit FSM
// that swaps banks only on a frame start, so no frame ever mixes two curves.
module gamma_lut_lane #(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 sr,
  input  logic                 ce,
  input  logic                 we,
  input  logic                 wbank,
  input  logic [IN_WIDTH-1:0]  waddr,
  input  logic [OUT_WIDTH-1:0] wdata,
  input  logic                 rvalid,
  input  logic                 rbank,
  input  logic [IN_WIDTH-1:0]  raddr,
  input  logic                 gc,
  output logic [OUT_WIDTH-1:0] dout
);
  localparam int DEPTH = 1 << IN_WIDTH;

  logic [OUT_WIDTH-1:0] mem [2*DEPTH];
  logic [OUT_WIDTH-1:0] byp;

  // Bypass keeps the sample MSB-aligned: drop or zero-fill LSBs.
  generate
    if (IN_WIDTH >= OUT_WIDTH) begin : g_trunc
      assign byp = raddr[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_pad
      assign byp = {raddr, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (ce && we) mem[{wbank, waddr}] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (sr)                dout <= '0;
    else if (ce && rvalid) dout <= gc ? mem[{rbank, raddr}] : byp;
  end
endmodule

module gamma_lut_pingpong #(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 8,
  parameter int NUM_CH    = 3,
  parameter int CH_SEL_W  = 2
) (
  input  logic                          clk,
  input  logic                          sr,
  input  logic                          ce,
  input  logic                          gcen,
  input  logic                          inpvalid,
  input  logic                          insof,
  input  logic [NUM_CH*IN_WIDTH-1:0]    din,
  input  logic                          lut_wr_valid,
  output logic                          lut_wr_ready,
  input  logic [CH_SEL_W-1:0]           lut_wr_ch,
  input  logic [IN_WIDTH-1:0]           lut_wr_addr,
  input  logic [OUT_WIDTH-1:0]          lut_wr_data,
  input  logic                          lut_commit,
  output logic                          swap_pending,
  output logic                          active_bank,
  output logic                          outvalid,
  output logic                          outsof,
  output logic                          gcvalid,
  output logic [NUM_CH*OUT_WIDTH-1:0]   dout
);
  localparam int STAGES = 2;

  typedef enum logic {OPEN, PENDING} state_t;
  state_t state;

  logic [STAGES:1] vld_pipe, sof_pipe, gc_pipe;
  logic [NUM_CH-1:0][IN_WIDTH-1:0] din_s1;
  logic bank_s1;
  logic sof_in, swap, wr_xfer;

  assign sof_in       = inpvalid & insof;
  assign swap         = (state == PENDING) & sof_in;
  assign lut_wr_ready = ce & (state == OPEN);
  assign wr_xfer      = lut_wr_valid & lut_wr_ready;
  assign outvalid     = vld_pipe[STAGES];
  assign outsof       = sof_pipe[STAGES];
  assign gcvalid      = gc_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (sr) begin
      state        <= OPEN;
      swap_pending <= 1'b0;
      active_bank  <= 1'b0;
    end else if (ce) begin
      case (state)
        OPEN: if (lut_commit) begin
          state        <= PENDING;
          swap_pending <= 1'b1;
        end
        PENDING: if (sof_in) begin
          state        <= OPEN;
          swap_pending <= 1'b0;
          active_bank  <= ~active_bank;
        end
        default: state <= OPEN;
      endcase
    end
  end

  // Stage 1 takes the post-swap bank so the SOF pixel already uses the new curve.
  always_ff @(posedge clk) begin
    if (sr) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
      gc_pipe  <= '0;
      bank_s1  <= 1'b0;
      din_s1   <= '0;
    end else if (ce) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], inpvalid};
      sof_pipe <= {sof_pipe[STAGES-1:1], sof_in};
      gc_pipe  <= {gc_pipe[STAGES-1:1], inpvalid & gcen};
      bank_s1  <= active_bank ^ swap;
      din_s1   <= din;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      gamma_lut_lane #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane (
        .clk    (clk),
        .sr     (sr),
        .ce     (ce),
        .we     (wr_xfer && (lut_wr_ch == CH_SEL_W'(k))),
        .wbank  (~active_bank),
        .waddr  (lut_wr_addr),
        .wdata  (lut_wr_data),
        .rvalid (vld_pipe[1]),
        .rbank  (bank_s1),
        .raddr  (din_s1[k]),
        .gc     (gc_pipe[1]),
        .dout   (dout[k*OUT_WIDTH +: OUT_WIDTH])
      );
    end
  endgenerate
endmodule

// File: doc/gamma_lut_pingpong.md
Name: gamma_lut_pingpong

Overview:
- Next-generation gamma corrector: NUM_CH parallel colour planes, each mapped through its own IN_WIDTH-addressed LUT to OUT_WIDTH output.
- Each channel LUT is double-banked (active/shadow). Software or a host FSM loads the shadow bank through a valid/ready write port while video runs from the active bank.
- A commit request swaps banks atomically at the next frame start, so no frame mixes two curves.
- Sits in the ISP pixel path between debayer/CCM and the output formatter.

Parameters:
- IN_WIDTH, 10, input sample width per channel; LUT depth = 2^IN_WIDTH.
- OUT_WIDTH, 8, output sample width per channel and LUT entry width.
- NUM_CH, 3, number of colour planes (1..4).
- CH_SEL_W, 2, width of the LUT channel selector; must satisfy 2^CH_SEL_W >= NUM_CH.

Ports:
- clk  in  1  system clock
- sr  in  1  synchronous reset, active-high
- ce  in  1  clock enable; 0 freezes all state
- gcen  in  1  1 = apply LUT, 0 = bypass
- inpvalid  in  1  input pixel valid
- insof  in  1  start-of-frame marker, qualified by inpvalid
- din  in  NUM_CH*IN_WIDTH  input pixel; channel k at bits [k*IN_WIDTH +: IN_WIDTH]
- lut_wr_valid  in  1  shadow-LUT write request
- lut_wr_ready  out  1  shadow-LUT write accepted
- lut_wr_ch  in  CH_SEL_W  target channel
- lut_wr_addr  in  IN_WIDTH  LUT address
- lut_wr_data  in  OUT_WIDTH  LUT entry
- lut_commit  in  1  request bank swap at next frame start
- swap_pending  out  1  commit accepted, swap not yet done
- active_bank  out  1  bank currently driving video
- outvalid  out  1  output pixel valid
- outsof  out  1  delayed insof
- gcvalid  out  1  output pixel was LUT-corrected (gcen captured with the pixel)
- dout  out  NUM_CH*OUT_WIDTH  output pixel, same channel packing as din

Behaviour:
- ce=0: no register, RAM write or handshake advances; lut_wr_ready is forced to 0.
- Reset (sr=1 at clk edge) clears: outvalid, outsof, gcvalid, dout, swap_pending, active_bank. Reset values are 0, and lut_wr_ready is 1 after reset. LUT RAM contents are not reset and are undefined until written.
- Latency: fixed 2 enabled cycles, din to dout.
  - Stage 1 registers din, inpvalid, insof, gcen and the bank select.
  - Stage 2 is the registered LUT read.
  - outvalid, outsof and gcvalid are delayed identically.
- Bypass (gcen=0): dout channel = din channel MSB-aligned.
  - IN_WIDTH > OUT_WIDTH: truncate LSBs.
  - IN_WIDTH < OUT_WIDTH: zero-pad LSBs.
  - gcvalid=0; same 2-cycle latency.
- Corrected mode: dout channel k = LUT[k][active bank][din channel k]; gcvalid = outvalid.
- Invalid input cycles: dout holds its previous value.
- Write port:
  - A transfer occurs when lut_wr_valid & lut_wr_ready & ce.
  - It writes lut_wr_data into the shadow bank (~active_bank) of channel lut_wr_ch at lut_wr_addr.
  - lut_wr_ch >= NUM_CH: handshake completes, no write.
- Commit FSM, two states:
  - OPEN: lut_wr_ready=1, swap_pending=0. lut_commit=1 -> PENDING.
  - PENDING: lut_wr_ready=0, swap_pending=1. On the first cycle with inpvalid & insof & ce: toggle active_bank, return to OPEN.
  - The new bank applies to that SOF pixel itself (bank select is sampled after the toggle in stage 1) and to all later pixels.
  - lut_commit while PENDING is ignored.
- Simultaneous lut_commit and write transfer in OPEN: the write completes to the old shadow bank, then the FSM enters PENDING.
- Simultaneous entry to PENDING and insof: the swap waits for the next frame start.
- sr mid-frame or while PENDING: pending swap dropped, active_bank=0, pipeline flushed (outvalid=0 the next cycle).
- Read/write to the same RAM address cannot collide, because writes only target the shadow bank.

Test Plan:
- Load bank1 ch0..2 with LUT[a]=a>>2 (IN=10, OUT=8), commit, drive insof pixel din={10'd1023,10'd512,10'd4}. Required: swap_pending 1 until SOF; active_bank=1; two cycles later dout={8'd255,8'd128,8'd1}, outsof=1, gcvalid=1.
- Bypass: gcen=0, din ch0=10'h3FF. Required: dout ch0=8'hFF, gcvalid=0, latency 2.
- Commit with no SOF for 100 pixels. Required: active_bank unchanged, lut_wr_ready=0 throughout, dout uses old bank; swap occurs on the next SOF.
- Write with lut_wr_ch=3 (NUM_CH=3). Required: handshake completes, no LUT content changes.
- ce toggled 0 for 5 cycles mid-stream. Required: outputs and FSM frozen, lut_wr_ready=0, latency counts only enabled cycles.
- sr asserted while PENDING. Required: next cycle swap_pending=0, active_bank=0, outvalid=0, lut_wr_ready=1.
